// File: rtl/data_memory.sv
// Word-organised data RAM with byte-lane writes and a programmable number of
// wait states; one-cycle Ack per completed access.
module data_memory #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        ReadEnable,
  input  logic        WriteEnable,
  input  logic [3:0]  ByteEnable,
  output logic [31:0] ReadData,
  output logic        Ack,
  output logic        Busy,
  output logic        AddrErr
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [3:0] WS    = 4'(WAIT_STATES);
  localparam int         DEPTH = 1 << ADDR_BITS;

  state_t state, state_next;

  logic [3:0]  cnt;
  logic [31:2] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        we_q;

  logic [31:0] mem [DEPTH];

  logic                 req;
  logic                 commit;
  logic [31:2]          eff_addr;
  logic [31:0]          eff_wdata;
  logic [3:0]           eff_be;
  logic                 eff_we;
  logic                 eff_err;
  logic [ADDR_BITS-1:0] eff_idx;

  // Byte offset is ignored; keeps the two LSBs visibly consumed.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^Address[1:0];

  assign req  = ReadEnable | WriteEnable;
  assign Busy = (state != ST_IDLE);

  // With zero wait states the access completes on the acceptance edge, so the
  // live inputs are used directly; otherwise the latched request is used.
  always_comb begin
    if (state == ST_IDLE) begin
      eff_addr  = Address[31:2];
      eff_wdata = WriteData;
      eff_be    = ByteEnable;
      eff_we    = WriteEnable;
    end else begin
      eff_addr  = addr_q;
      eff_wdata = wdata_q;
      eff_be    = be_q;
      eff_we    = we_q;
    end
    eff_idx = eff_addr[ADDR_BITS+1:2];
    eff_err = |eff_addr[31:ADDR_BITS+2];
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (req) begin
          state_next = (WS == 4'd0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd1) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign commit = (state_next == ST_DONE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      Ack      <= 1'b0;
      AddrErr  <= 1'b0;
      ReadData <= '0;
    end else begin
      state   <= state_next;
      Ack     <= commit;
      AddrErr <= commit & eff_err;

      if (state == ST_IDLE && req) begin
        addr_q  <= Address[31:2];
        wdata_q <= WriteData;
        be_q    <= ByteEnable;
        we_q    <= WriteEnable;
        cnt     <= WS;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end

      if (commit && !eff_we) begin
        ReadData <= eff_err ? '0 : mem[eff_idx];
      end
    end
  end

  // RAM has no reset; RST gates the commit so an interrupted write never lands.
  always_ff @(posedge CLK) begin
    if (!RST && commit && eff_we && !eff_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (eff_be[i]) begin
          mem[eff_idx][8*i +: 8] <= eff_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
